// File: rtl/parking_pkg.sv
// Shared types and constants for the car-park controller: gate FSM states,
// counter-width helper and default timing values for a 50 MHz clock.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OPEN       = 3'd1,
    WAIT_CLEAR = 3'd2,
    BLOCKED    = 3'd3,
    FAULT      = 3'd4
  } gate_state_t;

  localparam int DEF_NUM_SLOTS           = 6;
  localparam int DEF_DEBOUNCE_CYCLES     = 50000;
  localparam int DEF_GATE_OPEN_CYCLES    = 150000000;
  localparam int DEF_HOLD_TIMEOUT_CYCLES = 500000000;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int count_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output follows
// the synchronised input once it has held for DEBOUNCE_CYCLES cycles.
module input_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic debounced
);

  localparam int CW = count_width(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;

  // The count only runs while the synchronised value disagrees with the
  // output, so a bounce back to the old value restarts it from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable_cnt <= '0;
      debounced  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == debounced) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_cnt <= '0;
        debounced  <= sync2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park controller: debounced slot/entry sensors, free-space count and the
// entry-gate FSM. Define PARKING_FAULT_EN to add the gate-hold timeout/FAULT state.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS           = DEF_NUM_SLOTS,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int GATE_OPEN_CYCLES    = DEF_GATE_OPEN_CYCLES,
  parameter int HOLD_TIMEOUT_CYCLES = DEF_HOLD_TIMEOUT_CYCLES
) (
  input  logic                                 clock_50MHz,
  input  logic                                 reset,
  input  logic [NUM_SLOTS-1:0]                 pos,
  input  logic                                 infrared_input,
  output logic [NUM_SLOTS-1:0]                 leds,
  output logic                                 open_gate,
  output logic [count_width(NUM_SLOTS+1)-1:0]  free_count,
  output logic                                 lot_full,
  output logic                                 status_valid,
  output logic                                 denied,
  output logic                                 fault,
  output gate_state_t                          gate_state
);

  localparam int FW = count_width(NUM_SLOTS + 1);
  localparam int TW = count_width(GATE_OPEN_CYCLES);

  logic [NUM_SLOTS:0] raw_all;
  logic [NUM_SLOTS:0] db_all;
  logic               ir;
  logic               ir_prev;
  logic               ir_rise;

  // Bit NUM_SLOTS carries the entry infrared sensor alongside the slots.
  assign raw_all = {infrared_input, pos};

  for (genvar i = 0; i <= NUM_SLOTS; i++) begin : g_db
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clock_50MHz),
      .reset     (reset),
      .raw       (raw_all[i]),
      .debounced (db_all[i])
    );
  end

  assign leds    = db_all[NUM_SLOTS-1:0];
  assign ir      = db_all[NUM_SLOTS];
  assign ir_rise = ir & ~ir_prev;

  logic [FW-1:0] occupied;
  logic [FW-1:0] free_prev;

  always_comb begin
    occupied = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occupied = occupied + FW'(leds[i]);
    end
  end

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      free_count <= FW'(NUM_SLOTS);
      free_prev  <= FW'(NUM_SLOTS);
      ir_prev    <= 1'b0;
    end else begin
      free_count <= FW'(NUM_SLOTS) - occupied;
      free_prev  <= free_count;
      ir_prev    <= ir;
    end
  end

  assign lot_full     = (free_count == '0);
  assign status_valid = (free_count != free_prev);

  gate_state_t   state;
  gate_state_t   next_state;
  logic          deny_set;
  logic [TW-1:0] open_timer;
  logic          open_done;

  assign open_done = (open_timer == TW'(GATE_OPEN_CYCLES - 1));

`ifdef PARKING_FAULT_EN
  localparam int HW = count_width(HOLD_TIMEOUT_CYCLES);

  logic [HW-1:0] hold_timer;
  logic          hold_done;
  logic          fault_q;

  assign hold_done = (hold_timer == HW'(HOLD_TIMEOUT_CYCLES - 1));
  assign fault     = fault_q;

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      hold_timer <= '0;
      fault_q    <= 1'b0;
    end else begin
      hold_timer <= (state == WAIT_CLEAR && next_state == WAIT_CLEAR) ? hold_timer + 1'b1 : '0;
      if (state == WAIT_CLEAR && next_state == FAULT) fault_q <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      state      <= IDLE;
      open_timer <= '0;
      denied     <= 1'b0;
    end else begin
      state      <= next_state;
      open_timer <= (state == OPEN && next_state == OPEN) ? open_timer + 1'b1 : '0;
      denied     <= deny_set;
    end
  end

  // Admission uses the registered free_count, so a slot freeing in the same
  // cycle as an arrival is only seen one cycle later from BLOCKED.
  always_comb begin
    next_state = state;
    deny_set   = 1'b0;
    case (state)
      IDLE: begin
        if (ir_rise) begin
          if (free_count != '0) begin
            next_state = OPEN;
          end else begin
            next_state = BLOCKED;
            deny_set   = 1'b1;
          end
        end
      end
      OPEN: begin
        if (open_done) next_state = ir ? WAIT_CLEAR : IDLE;
      end
      WAIT_CLEAR: begin
        if (!ir) next_state = IDLE;
`ifdef PARKING_FAULT_EN
        else if (hold_done) next_state = FAULT;
`endif
      end
      BLOCKED: begin
        if (!ir) next_state = IDLE;
        else if (free_count != '0) next_state = OPEN;
      end
`ifdef PARKING_FAULT_EN
      FAULT: begin
        if (!ir) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  assign open_gate  = (state == OPEN) || (state == WAIT_CLEAR);
  assign gate_state = state;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with short debounce/gate timings.
module tb_parking_gate_ctrl;
  import parking_pkg::*;

  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     pos;
  logic              ir_in;
  logic [NS-1:0]     leds;
  logic              open_gate;
  logic [2:0]        free_count;
  logic              lot_full;
  logic              status_valid;
  logic              denied;
  logic              fault;
  gate_state_t       gate_state;

  int checks = 0;
  int errors = 0;
  int sv_cnt, den_cnt, open_cnt, busy_cnt;

  parking_gate_ctrl #(
    .NUM_SLOTS(NS), .DEBOUNCE_CYCLES(4), .GATE_OPEN_CYCLES(10), .HOLD_TIMEOUT_CYCLES(20)
  ) dut (
    .clock_50MHz    (clk),
    .reset          (reset),
    .pos            (pos),
    .infrared_input (ir_in),
    .leds           (leds),
    .open_gate      (open_gate),
    .free_count     (free_count),
    .lot_full       (lot_full),
    .status_valid   (status_valid),
    .denied         (denied),
    .fault          (fault),
    .gate_state     (gate_state)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clr_counts();
    sv_cnt = 0; den_cnt = 0; open_cnt = 0; busy_cnt = 0;
  endtask

  // Advance n cycles; outputs are sampled 1 time unit after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (status_valid) sv_cnt++;
      if (denied) den_cnt++;
      if (open_gate) open_cnt++;
      if (gate_state != IDLE) busy_cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pos   = '0;
    ir_in = 1'b0;
    run(3);
    reset = 1'b0;
    clr_counts();
  endtask

  initial begin
    do_reset();
    reset = 1'b1;
    run(1);
    check("rst_leds", leds, 0);
    check("rst_open", open_gate, 0);
    check("rst_free", free_count, 4);
    check("rst_full", lot_full, 0);
    check("rst_sv", status_valid, 0);
    check("rst_denied", denied, 0);
    check("rst_fault", fault, 0);
    check("rst_state", gate_state, IDLE);

    // Slot occupancy, debounce latency and glitch rejection.
    do_reset();
    pos = 4'b0011;
    run(5);
    check("s1_leds_c5", leds, 0);
    run(1);
    check("s1_leds_c6", leds, 4'b0011);
    check("s1_free_c6", free_count, 4);
    run(1);
    check("s1_free_c7", free_count, 2);
    check("s1_sv_c7", status_valid, 1);
    run(5);
    check("s1_sv_count", sv_cnt, 1);
    check("s1_full", lot_full, 0);
    clr_counts();
    pos = 4'b1011;
    run(3);
    pos = 4'b0011;
    run(10);
    check("s1_glitch_leds", leds, 4'b0011);
    check("s1_glitch_free", free_count, 2);
    check("s1_glitch_sv", sv_cnt, 0);

    // Infrared pulse too short to pass the debouncer.
    do_reset();
    ir_in = 1'b1;
    run(3);
    ir_in = 1'b0;
    run(15);
    check("s2_open_cnt", open_cnt, 0);
    check("s2_den_cnt", den_cnt, 0);
    check("s2_busy_cnt", busy_cnt, 0);

    // Car held in the gate beyond the minimum open time.
    do_reset();
    ir_in = 1'b1;
    run(6);
    check("s3_open_c6", open_gate, 0);
    run(1);
    check("s3_open_c7", open_gate, 1);
    check("s3_state_c7", gate_state, OPEN);
    run(13);
    check("s3_open_c20", open_gate, 1);
    check("s3_state_c20", gate_state, WAIT_CLEAR);
    run(10);
    ir_in = 1'b0;
    run(6);
    check("s3_open_c36", open_gate, 1);
    run(1);
    check("s3_open_c37", open_gate, 0);
    check("s3_state_c37", gate_state, IDLE);
    check("s3_den_cnt", den_cnt, 0);

    // Full lot: denial, then admission from BLOCKED once a slot frees.
    do_reset();
    pos = 4'b1111;
    run(7);
    check("s4_free_full", free_count, 0);
    check("s4_lot_full", lot_full, 1);
    clr_counts();
    ir_in = 1'b1;
    run(7);
    check("s4_denied_c7", denied, 1);
    check("s4_state_c7", gate_state, BLOCKED);
    run(5);
    check("s4_den_cnt", den_cnt, 1);
    check("s4_open_cnt", open_cnt, 0);
    pos = 4'b1011;
    run(7);
    check("s4_free_one", free_count, 1);
    check("s4_open_c7", open_gate, 0);
    run(1);
    check("s4_open_c8", open_gate, 1);
    check("s4_state_c8", gate_state, OPEN);
    check("s4_den_total", den_cnt, 1);

    // Short car: gate open exactly the minimum time.
    do_reset();
    ir_in = 1'b1;
    run(10);
    ir_in = 1'b0;
    run(6);
    check("s5_open_c16", open_gate, 1);
    run(1);
    check("s5_open_c17", open_gate, 0);
    check("s5_state_c17", gate_state, IDLE);
    run(10);
    check("s5_open_cnt", open_cnt, 10);

`ifdef PARKING_FAULT_EN
    // Car never clears: timeout closes the gate and latches fault.
    do_reset();
    ir_in = 1'b1;
    run(36);
    check("s6_open_c36", open_gate, 1);
    check("s6_fault_c36", fault, 0);
    run(1);
    check("s6_open_c37", open_gate, 0);
    check("s6_state_c37", gate_state, FAULT);
    check("s6_fault_c37", fault, 1);
    run(13);
    ir_in = 1'b0;
    run(7);
    check("s6_state_idle", gate_state, IDLE);
    check("s6_fault_sticky", fault, 1);
    do_reset();
    check("s6_fault_rst", fault, 0);
`else
    // Without the timeout the gate waits for the car indefinitely.
    do_reset();
    ir_in = 1'b1;
    run(45);
    check("s6_state_wait", gate_state, WAIT_CLEAR);
    check("s6_open_held", open_gate, 1);
    check("s6_fault_tied", fault, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
